ddr_cmd_sequencer: RTL and testbench
====================================

// Module: ddr_cmd_sequencer
// PURPOSE
//  Receiving end of the scheduler's command interface. Takes the one-cycle {cmd, index} issued by
//  timing_controller and encodes it onto the DDR4 command/address pins, holding it for the
//  3-cycle command slot. Tracks every in-flight READ/WRITE and opens the matching data window
//  (write-data drive or read-data capture) at the fixed latency, tagged with the burst index.
// PARAMETERS
//  NO_OF_BURSTS  4   number of burst buffers; width of cmd_index_i is $clog2(NO_OF_BURSTS)
//  CMD_CYCLES    3   cycles one command occupies the CA bus
//  WR_TO_DATA    24  cycles from WRITE slot start to first write-data beat
//  RD_TO_DATA    27  cycles from READ slot start to first read-data beat
//  BURST_TIME    8   data window length in cycles
//  TRACK_DEPTH   4   max in-flight READ/WRITE commands tracked
// PORTS
//  clk                   in   1      clock
//  rst_n                 in   1      asynchronous reset, active low
//  burst_cmd_i           in   command  scheduler command; none = idle
//  cmd_index_i           in   $clog2(NO_OF_BURSTS)  burst that owns the command
//  in_burst_address_bg   in   [NO_OF_BURSTS][2]   bank group per burst
//  in_burst_address_bank in   [NO_OF_BURSTS][2]   bank per burst
//  in_burst_address_row  in   [NO_OF_BURSTS][16]  row per burst
//  in_burst_address_col  in   [NO_OF_BURSTS][10]  column per burst
//  cs_n_o, act_n_o       out  1      DDR4 chip select / activate
//  ras_n_a16_o, cas_n_a15_o, we_n_a14_o  out 1 each  multiplexed command/address pins
//  bg_o, ba_o            out  2 each  bank group / bank
//  addr_o                out  14     A13..A0
//  wr_data_en_o          out  1      high during write window; burst drives DQ
//  rd_capture_o          out  1      high during read window; burst captures DQ
//  data_index_o          out  $clog2(NO_OF_BURSTS)  burst owning the current window
//  data_done_o           out  1      1-cycle pulse on the last beat of any window
//  err_o                 out  2      sticky {data_collision, cmd_overrun}
// BEHAVIOUR
//  - Reset (async, rst_n=0): cs_n/act_n/ras/cas/we/addr = all-ones; bg/ba = 0. wr_data_en, rd_capture,
//    data_index, data_done and err = 0. Slot counter idle, tracker empty. In-flight commands are discarded.
//  - Capture: burst_cmd_i != none while the slot is idle -> latch cmd and the bg/ba/row/col selected by
//    cmd_index_i. The pins change on the next edge (cycle T = slot start).
//  - Slot: cycle T drives cs_n=0 and the encoding below. Cycles T+1..T+CMD_CYCLES-1 drive cs_n=1 and hold
//    the other pins. The slot is idle again at T+CMD_CYCLES.
//  - Overrun: command arrives while the slot is busy -> drop it, set err_o[0]; the current slot is unaffected.
//  - Encoding (act_n,ras,cas,we). Idle/deselect: cs_n=1, all pins high.
//      ACTIVATE  0, ras=0, cas=row[15], we=row[14], addr=row[13:0]
//      READ      1,1,0,1; addr[9:0]=col, A10=0 (no auto-precharge), A12=1 (BL8), others 0
//      WRITE     1,1,0,0; addr as READ
//      PRECHARGE 1,0,1,0; A10=0 (single bank)
//      REFRESH_ALL 1,0,0,1; bg/ba=0
//  - Tracker: at T for READ/WRITE, allocate a free entry {type, index, countdown=latency-1}.
//    All valid countdowns decrement every cycle. An entry reaching 0 starts its window the next cycle:
//    output high for exactly BURST_TIME cycles, data_index_o = entry index.
//    data_done_o pulses on the last beat, then the entry frees.
//    So the first beat is at T+WR_TO_DATA / T+RD_TO_DATA.
//  - Collision: a window starts while another is active -> set err_o[1]; the newer window preempts the
//    outputs and the older entry is dropped.
//  - Tracker full at allocation -> command still issued on pins, no window, err_o[1] set.
//  - A window starting in the same cycle another ends: back-to-back, no gap, no error.
//  - err_o clears only on reset.
// STRUCTURE
//  - types_def package: command, r_type, CMD_CYCLES, WR_TO_DATA, RD_TO_DATA, BURST_TIME. The scheduler and
//    this block use the same constants. Add a ddr4_ca_t struct for the pin bundle.
//  - One sub-module: data_window_tracker (TRACK_DEPTH countdown entries, window FSM IDLE/ACTIVE,
//    collision/full detect).
//  - Top module: capture register, slot counter (0..CMD_CYCLES-1), pin encoder.
// TESTING
//  1. ACTIVATE idx2 (bg=1,ba=3,row=16'hC123) at T-1 -> cycle T: cs_n=0, act_n=0, ras=0, cas=1, we=1,
//     addr=14'h0123. cs_n=1 at T+1 and T+2.
//  2. WRITE idx1 (col=10'h2A) -> cmd=1100, addr=0x102A. wr_data_en_o high T+24..T+31 with
//     data_index_o=1; data_done_o pulse at T+31.
//  3. READ idx3 then READ idx0 4 cycles later -> rd_capture_o windows at T+27..34 and T+31..38.
//     err_o[1]=1 and data_index_o switches to 0 at T+31.
//  4. READ at T, READ at T+8 -> contiguous 16-cycle capture, index changes at T+35, no error.
//  5. Command on the cycle after a capture -> dropped, err_o[0]=1, pins untouched.
//  6. rst_n low at T+10 of a pending READ -> all outputs at reset values immediately; no window ever opens.

Source files
------------

// File: rtl/types_def.sv
// rtl/types_def.sv - command types, timing constants and DDR4 CA pin bundle shared with the scheduler
package types_def;

  typedef enum logic [2:0] {
    NONE        = 3'd0,
    ACTIVATE    = 3'd1,
    READ        = 3'd2,
    WRITE       = 3'd3,
    PRECHARGE   = 3'd4,
    REFRESH_ALL = 3'd5
  } command;

  typedef enum logic {
    R_WRITE = 1'b0,
    R_READ  = 1'b1
  } r_type;

  typedef enum logic {
    WIN_IDLE   = 1'b0,
    WIN_ACTIVE = 1'b1
  } win_state_t;

  localparam int CMD_CYCLES = 3;
  localparam int WR_TO_DATA = 24;
  localparam int RD_TO_DATA = 27;
  localparam int BURST_TIME = 8;

  typedef struct packed {
    logic        cs_n;
    logic        act_n;
    logic        ras_n_a16;
    logic        cas_n_a15;
    logic        we_n_a14;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] addr;
  } ddr4_ca_t;

  localparam ddr4_ca_t CA_IDLE = '{cs_n: 1'b1, act_n: 1'b1, ras_n_a16: 1'b1, cas_n_a15: 1'b1,
                                   we_n_a14: 1'b1, bg: 2'b00, ba: 2'b00, addr: 14'h3FFF};

  // Pin image for the first cycle of a command slot (cs_n asserted).
  function automatic ddr4_ca_t ca_encode(input command c, input logic [1:0] bg, input logic [1:0] ba,
                                         input logic [15:0] row, input logic [9:0] col);
    ddr4_ca_t ca;
    ca      = CA_IDLE;
    ca.cs_n = 1'b0;
    ca.bg   = bg;
    ca.ba   = ba;
    case (c)
      ACTIVATE: begin
        ca.act_n     = 1'b0;
        ca.ras_n_a16 = 1'b0;
        ca.cas_n_a15 = row[15];
        ca.we_n_a14  = row[14];
        ca.addr      = row[13:0];
      end
      READ, WRITE: begin
        ca.ras_n_a16 = 1'b1;
        ca.cas_n_a15 = 1'b0;
        ca.we_n_a14  = (c == READ);
        ca.addr      = {4'b0100, col};
      end
      PRECHARGE: begin
        ca.ras_n_a16 = 1'b0;
        ca.cas_n_a15 = 1'b1;
        ca.we_n_a14  = 1'b0;
        ca.addr      = 14'h0000;
      end
      REFRESH_ALL: begin
        ca.ras_n_a16 = 1'b0;
        ca.cas_n_a15 = 1'b0;
        ca.we_n_a14  = 1'b1;
        ca.bg        = 2'b00;
        ca.ba        = 2'b00;
        ca.addr      = 14'h0000;
      end
      default: ca = CA_IDLE;
    endcase
    return ca;
  endfunction

endpackage

// File: rtl/ddr_cmd_sequencer_if.sv
// rtl/ddr_cmd_sequencer_if.sv - DDR4 command/address pin bundle driven by the sequencer
interface ddr_cmd_sequencer_if;
  logic        cs_n_o;
  logic        act_n_o;
  logic        ras_n_a16_o;
  logic        cas_n_a15_o;
  logic        we_n_a14_o;
  logic [1:0]  bg_o;
  logic [1:0]  ba_o;
  logic [13:0] addr_o;

  modport master (output cs_n_o, act_n_o, ras_n_a16_o, cas_n_a15_o, we_n_a14_o, bg_o, ba_o, addr_o);
  modport slave  (input  cs_n_o, act_n_o, ras_n_a16_o, cas_n_a15_o, we_n_a14_o, bg_o, ba_o, addr_o);
endinterface

// File: rtl/data_window_tracker.sv
// rtl/data_window_tracker.sv - in-flight READ/WRITE countdowns and the data window FSM
module data_window_tracker
  import types_def::*;
#(
  parameter int TRACK_DEPTH = 4,
  parameter int IW          = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alloc_valid_i,
  input  r_type         alloc_type_i,
  input  logic [IW-1:0] alloc_index_i,
  output logic          win_active_o,
  output r_type         win_type_o,
  output logic [IW-1:0] win_index_o,
  output logic          win_last_o,
  output logic          error_o
);
  localparam int CW = $clog2(RD_TO_DATA);
  localparam int BW = $clog2(BURST_TIME);
  localparam int TW = (TRACK_DEPTH > 1) ? $clog2(TRACK_DEPTH) : 1;

  typedef struct packed {
    logic          vld;
    logic          run;
    r_type         typ;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
  } entry_t;

  entry_t        ent_q [TRACK_DEPTH];
  entry_t        ent_d [TRACK_DEPTH];
  win_state_t    state_q, state_d;
  logic [TW-1:0] own_q, own_d;
  logic [BW-1:0] beat_q, beat_d;
  r_type         wtyp_q, wtyp_d;
  logic [IW-1:0] widx_q, widx_d;
  logic          start, ending, found;
  logic [TW-1:0] start_sel;
  int            lat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TRACK_DEPTH; i++) ent_q[i] <= '0;
      state_q <= WIN_IDLE;
      own_q   <= '0;
      beat_q  <= '0;
      wtyp_q  <= R_WRITE;
      widx_q  <= '0;
    end else begin
      for (int i = 0; i < TRACK_DEPTH; i++) ent_q[i] <= ent_d[i];
      state_q <= state_d;
      own_q   <= own_d;
      beat_q  <= beat_d;
      wtyp_q  <= wtyp_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    for (int i = 0; i < TRACK_DEPTH; i++) ent_d[i] = ent_q[i];
    state_d   = state_q;
    own_d     = own_q;
    beat_d    = beat_q;
    wtyp_d    = wtyp_q;
    widx_d    = widx_q;
    error_o   = 1'b0;
    start     = 1'b0;
    start_sel = '0;
    found     = 1'b0;
    lat       = 0;
    ending    = (state_q == WIN_ACTIVE) && (beat_q == BW'(BURST_TIME - 1));

    // Entries expiring together: the first wins the window, the rest are lost.
    for (int i = 0; i < TRACK_DEPTH; i++) begin
      if (ent_q[i].vld && !ent_q[i].run) begin
        if (ent_q[i].cnt == '0) begin
          if (!start) begin
            start         = 1'b1;
            start_sel     = TW'(i);
            ent_d[i].run  = 1'b1;
          end else begin
            ent_d[i].vld  = 1'b0;
            error_o       = 1'b1;
          end
        end else begin
          ent_d[i].cnt = ent_q[i].cnt - 1'b1;
        end
      end
    end

    case (state_q)
      WIN_IDLE: begin
        if (start) begin
          state_d = WIN_ACTIVE;
          beat_d  = '0;
          own_d   = start_sel;
          wtyp_d  = ent_q[start_sel].typ;
          widx_d  = ent_q[start_sel].idx;
        end
      end
      default: begin
        if (start) begin
          // Preemption is an error unless the old window is on its last beat.
          if (!ending) error_o = 1'b1;
          ent_d[own_q].vld = 1'b0;
          ent_d[own_q].run = 1'b0;
          beat_d  = '0;
          own_d   = start_sel;
          wtyp_d  = ent_q[start_sel].typ;
          widx_d  = ent_q[start_sel].idx;
        end else if (ending) begin
          ent_d[own_q].vld = 1'b0;
          ent_d[own_q].run = 1'b0;
          state_d = WIN_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
    endcase

    // Countdown is loaded one cycle after slot start, so it starts at latency-2.
    if (alloc_valid_i) begin
      lat = (alloc_type_i == R_READ) ? (RD_TO_DATA - 2) : (WR_TO_DATA - 2);
      for (int i = 0; i < TRACK_DEPTH; i++) begin
        if (!ent_q[i].vld && !found) begin
          found    = 1'b1;
          ent_d[i] = '{vld: 1'b1, run: 1'b0, typ: alloc_type_i, idx: alloc_index_i, cnt: CW'(lat)};
        end
      end
      if (!found) error_o = 1'b1;
    end
  end

  assign win_active_o = (state_q == WIN_ACTIVE);
  assign win_type_o   = wtyp_q;
  assign win_index_o  = widx_q;
  assign win_last_o   = ending;

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// rtl/ddr_cmd_sequencer.sv - encodes scheduler commands onto DDR4 CA pins and opens data windows
module ddr_cmd_sequencer
  import types_def::*;
#(
  parameter  int NO_OF_BURSTS = 4,
  parameter  int TRACK_DEPTH  = 4,
  localparam int IW           = (NO_OF_BURSTS > 1) ? $clog2(NO_OF_BURSTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  command                        burst_cmd_i,
  input  logic [IW-1:0]                 cmd_index_i,
  input  logic [NO_OF_BURSTS-1:0][1:0]  in_burst_address_bg,
  input  logic [NO_OF_BURSTS-1:0][1:0]  in_burst_address_bank,
  input  logic [NO_OF_BURSTS-1:0][15:0] in_burst_address_row,
  input  logic [NO_OF_BURSTS-1:0][9:0]  in_burst_address_col,
  ddr_cmd_sequencer_if.master           ca_if,
  output logic                          wr_data_en_o,
  output logic                          rd_capture_o,
  output logic [IW-1:0]                 data_index_o,
  output logic                          data_done_o,
  output logic [1:0]                    err_o
);
  localparam int SW = $clog2(CMD_CYCLES);

  ddr4_ca_t      ca_q, ca_d;
  logic          busy_q, busy_d;
  logic [SW-1:0] slot_q, slot_d;
  command        cmd_q, cmd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ovr_q, ovr_d;
  logic          coll_q, coll_d;
  logic          alloc_v, trk_err, win_active, win_last;
  r_type         alloc_type, win_type;
  logic [IW-1:0] win_index;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ca_q   <= CA_IDLE;
      busy_q <= 1'b0;
      slot_q <= '0;
      cmd_q  <= NONE;
      idx_q  <= '0;
      ovr_q  <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      ca_q   <= ca_d;
      busy_q <= busy_d;
      slot_q <= slot_d;
      cmd_q  <= cmd_d;
      idx_q  <= idx_d;
      ovr_q  <= ovr_d;
      coll_q <= coll_d;
    end
  end

  always_comb begin
    ca_d   = ca_q;
    busy_d = busy_q;
    slot_d = slot_q;
    cmd_d  = cmd_q;
    idx_d  = idx_q;
    ovr_d  = ovr_q;
    coll_d = coll_q | trk_err;
    if (busy_q) begin
      if (slot_q == SW'(CMD_CYCLES - 1)) begin
        busy_d = 1'b0;
        slot_d = '0;
        ca_d   = CA_IDLE;
      end else begin
        slot_d    = slot_q + 1'b1;
        ca_d.cs_n = 1'b1;
      end
      if (burst_cmd_i != NONE) ovr_d = 1'b1;
    end else if (burst_cmd_i != NONE) begin
      busy_d = 1'b1;
      slot_d = '0;
      cmd_d  = burst_cmd_i;
      idx_d  = cmd_index_i;
      ca_d   = ca_encode(burst_cmd_i, in_burst_address_bg[cmd_index_i],
                         in_burst_address_bank[cmd_index_i], in_burst_address_row[cmd_index_i],
                         in_burst_address_col[cmd_index_i]);
    end
  end

  assign alloc_v    = busy_q && (slot_q == '0) && ((cmd_q == READ) || (cmd_q == WRITE));
  assign alloc_type = (cmd_q == READ) ? R_READ : R_WRITE;

  data_window_tracker #(
    .TRACK_DEPTH (TRACK_DEPTH),
    .IW          (IW)
  ) u_tracker (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_valid_i (alloc_v),
    .alloc_type_i  (alloc_type),
    .alloc_index_i (idx_q),
    .win_active_o  (win_active),
    .win_type_o    (win_type),
    .win_index_o   (win_index),
    .win_last_o    (win_last),
    .error_o       (trk_err)
  );

  assign ca_if.cs_n_o      = ca_q.cs_n;
  assign ca_if.act_n_o     = ca_q.act_n;
  assign ca_if.ras_n_a16_o = ca_q.ras_n_a16;
  assign ca_if.cas_n_a15_o = ca_q.cas_n_a15;
  assign ca_if.we_n_a14_o  = ca_q.we_n_a14;
  assign ca_if.bg_o        = ca_q.bg;
  assign ca_if.ba_o        = ca_q.ba;
  assign ca_if.addr_o      = ca_q.addr;

  assign wr_data_en_o = win_active && (win_type == R_WRITE);
  assign rd_capture_o = win_active && (win_type == R_READ);
  assign data_index_o = win_index;
  assign data_done_o  = win_last;
  assign err_o        = {coll_q, ovr_q};

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// tb/tb_ddr_cmd_sequencer.sv - directed vectors for ddr_cmd_sequencer
module tb_ddr_cmd_sequencer;
  import types_def::*;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  command           burst_cmd_i = NONE;
  logic [1:0]       cmd_index_i = 2'd0;
  logic [3:0][1:0]  bg_a;
  logic [3:0][1:0]  ba_a;
  logic [3:0][15:0] row_a;
  logic [3:0][9:0]  col_a;
  logic             wr_data_en_o, rd_capture_o, data_done_o;
  logic [1:0]       data_index_o, err_o;

  int vec_cnt     = 0;
  int miscompares = 0;
  int now         = 0;
  int t0          = 0;
  int s           = 0;
  logic seen;

  ddr_cmd_sequencer_if ca_if ();

  ddr_cmd_sequencer #(
    .NO_OF_BURSTS (4),
    .TRACK_DEPTH  (4)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .burst_cmd_i           (burst_cmd_i),
    .cmd_index_i           (cmd_index_i),
    .in_burst_address_bg   (bg_a),
    .in_burst_address_bank (ba_a),
    .in_burst_address_row  (row_a),
    .in_burst_address_col  (col_a),
    .ca_if                 (ca_if),
    .wr_data_en_o          (wr_data_en_o),
    .rd_capture_o          (rd_capture_o),
    .data_index_o          (data_index_o),
    .data_done_o           (data_done_o),
    .err_o                 (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, now);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      now++;
    end
  endtask

  task automatic wait_to(input int t);
    while (now < t) step(1);
  endtask

  task automatic issue(input command c, input logic [1:0] idx);
    burst_cmd_i = c;
    cmd_index_i = idx;
    step(1);
    burst_cmd_i = NONE;
    t0 = now;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  function automatic logic [31:0] pins4();
    return 32'({ca_if.act_n_o, ca_if.ras_n_a16_o, ca_if.cas_n_a15_o, ca_if.we_n_a14_o});
  endfunction

  initial begin
    bg_a  = '0;
    ba_a  = '0;
    row_a = '0;
    col_a = '0;
    bg_a[2]  = 2'd1;
    ba_a[2]  = 2'd3;
    row_a[2] = 16'hC123;
    bg_a[1]  = 2'd2;
    ba_a[1]  = 2'd1;
    col_a[1] = 10'h02A;
    col_a[3] = 10'h155;
    col_a[0] = 10'h0F0;

    step(2);
    check_vec("rst_cs_n", 32'(ca_if.cs_n_o), 32'd1);
    check_vec("rst_pins", pins4(), 32'hF);
    check_vec("rst_addr", 32'(ca_if.addr_o), 32'h3FFF);
    check_vec("rst_bgba", 32'({ca_if.bg_o, ca_if.ba_o}), 32'd0);
    check_vec("rst_win", 32'({wr_data_en_o, rd_capture_o, data_done_o}), 32'd0);
    check_vec("rst_idx_err", 32'({data_index_o, err_o}), 32'd0);
    rst_n = 1'b1;
    step(1);

    // ACTIVATE encoding and 3-cycle slot
    issue(ACTIVATE, 2'd2);
    check_vec("act_cs_n", 32'(ca_if.cs_n_o), 32'd0);
    check_vec("act_pins", pins4(), 32'h3);
    check_vec("act_addr", 32'(ca_if.addr_o), 32'h0123);
    check_vec("act_bgba", 32'({ca_if.bg_o, ca_if.ba_o}), 32'h7);
    step(1);
    check_vec("act_t1_cs_n", 32'(ca_if.cs_n_o), 32'd1);
    check_vec("act_t1_hold", pins4(), 32'h3);
    check_vec("act_t1_addr", 32'(ca_if.addr_o), 32'h0123);
    step(1);
    check_vec("act_t2_cs_n", 32'(ca_if.cs_n_o), 32'd1);
    step(1);
    check_vec("act_t3_idle", pins4(), 32'hF);
    check_vec("act_t3_addr", 32'(ca_if.addr_o), 32'h3FFF);

    // WRITE and its data window
    issue(WRITE, 2'd1);
    s = t0;
    check_vec("wr_pins", pins4(), 32'hC);
    check_vec("wr_addr", 32'(ca_if.addr_o), 32'h102A);
    check_vec("wr_bgba", 32'({ca_if.bg_o, ca_if.ba_o}), 32'h9);
    wait_to(s + 23);
    check_vec("wr_pre", 32'(wr_data_en_o), 32'd0);
    wait_to(s + 24);
    check_vec("wr_first", 32'({wr_data_en_o, rd_capture_o, data_done_o}), 32'b100);
    check_vec("wr_idx", 32'(data_index_o), 32'd1);
    wait_to(s + 31);
    check_vec("wr_last", 32'({wr_data_en_o, data_done_o}), 32'b11);
    wait_to(s + 32);
    check_vec("wr_after", 32'({wr_data_en_o, data_done_o}), 32'b00);
    check_vec("wr_err", 32'(err_o), 32'd0);

    // overlapping READs: collision, newer window wins
    issue(READ, 2'd3);
    s = t0;
    wait_to(s + 3);
    issue(READ, 2'd0);
    check_vec("rd2_pins", pins4(), 32'hD);
    check_vec("rd2_addr", 32'(ca_if.addr_o), 32'h10F0);
    wait_to(s + 26);
    check_vec("col_pre", 32'(rd_capture_o), 32'd0);
    wait_to(s + 27);
    check_vec("col_first", 32'({rd_capture_o, data_index_o}), 32'b111);
    wait_to(s + 30);
    check_vec("col_err_before", 32'(err_o), 32'd0);
    wait_to(s + 31);
    check_vec("col_switch", 32'({rd_capture_o, data_index_o}), 32'b100);
    check_vec("col_err", 32'(err_o), 32'b10);
    wait_to(s + 34);
    check_vec("col_old_dropped", 32'({rd_capture_o, data_done_o}), 32'b10);
    wait_to(s + 38);
    check_vec("col_last", 32'({rd_capture_o, data_done_o}), 32'b11);
    wait_to(s + 39);
    check_vec("col_after", 32'(rd_capture_o), 32'd0);

    // back-to-back READs, no gap, no error
    do_reset();
    issue(READ, 2'd1);
    s = t0;
    wait_to(s + 7);
    issue(READ, 2'd2);
    wait_to(s + 34);
    check_vec("b2b_end1", 32'({rd_capture_o, data_done_o, data_index_o}), 32'b1101);
    wait_to(s + 35);
    check_vec("b2b_start2", 32'({rd_capture_o, data_done_o, data_index_o}), 32'b1010);
    wait_to(s + 42);
    check_vec("b2b_end2", 32'({rd_capture_o, data_done_o}), 32'b11);
    wait_to(s + 43);
    check_vec("b2b_after", 32'(rd_capture_o), 32'd0);
    check_vec("b2b_err", 32'(err_o), 32'd0);

    // overrun: second command during busy slot is dropped
    do_reset();
    issue(PRECHARGE, 2'd0);
    check_vec("pre_pins", pins4(), 32'hA);
    check_vec("pre_addr", 32'(ca_if.addr_o), 32'h0000);
    burst_cmd_i = ACTIVATE;
    cmd_index_i = 2'd2;
    step(1);
    burst_cmd_i = NONE;
    check_vec("ovr_hold", 32'({ca_if.cs_n_o, pins4()[3:0]}), 32'h1A);
    check_vec("ovr_err", 32'(err_o), 32'b01);
    wait_to(t0 + 3);
    check_vec("ovr_dropped", 32'({ca_if.cs_n_o, pins4()[3:0]}), 32'h1F);
    wait_to(t0 + 4);
    check_vec("ovr_still_idle", 32'(ca_if.cs_n_o), 32'd1);

    // tracker full on the fifth in-flight READ
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) wait_to(t0 + 3);
      issue(READ, 2'(k));
    end
    check_vec("full_before", 32'(err_o), 32'd0);
    step(1);
    check_vec("full_err", 32'(err_o), 32'b10);

    // reset while a READ is pending
    do_reset();
    issue(READ, 2'd3);
    s = t0;
    wait_to(s + 10);
    rst_n = 1'b0;
    #1;
    check_vec("prst_pins", 32'({ca_if.cs_n_o, pins4()[3:0]}), 32'h1F);
    check_vec("prst_out", 32'({wr_data_en_o, rd_capture_o, data_done_o, data_index_o, err_o}), 32'd0);
    step(1);
    rst_n = 1'b1;
    seen = 1'b0;
    while (now < s + 45) begin
      step(1);
      if (rd_capture_o || wr_data_en_o) seen = 1'b1;
    end
    check_vec("prst_no_window", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
